// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit frame buffer.
package eth_pkg;

   typedef enum logic [2:0] {
      FILL     = 3'd0,
      DROP     = 3'd1,
      WAIT_ACK = 3'd2,
      SEND     = 3'd3,
      GAP      = 3'd4
   } state_t;

   localparam int unsigned ETH_MIN_FRAME = 60;
   localparam int unsigned ETH_MAX_FRAME = 1514;
   localparam logic [7:0]  PAD_BYTE      = 8'h00;

endpackage

// File: rtl/eth_tx_buf_ram.sv
// Simple dual-port frame RAM: one write port, one read port with a
// registered (1-cycle latency) read output.
module eth_tx_buf_ram
   import eth_pkg::*;
#(
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem_r [2**ADDR_W];

   // Write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port
   always_ff @(posedge clk) begin
      rd_data <= mem_r[rd_addr];
   end

endmodule

// File: rtl/eth_tx_frame_buffer.sv
// Store-and-forward TX buffer feeding an 8-bit MAC client interface.
// Optional ETH_TX_PAD_EN: short frames are zero-padded to 60 bytes on transmit.
module eth_tx_frame_buffer
   import eth_pkg::*;
#(
   parameter int unsigned MAX_LEN = ETH_MAX_FRAME,
   parameter int unsigned ADDR_W  = 11
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [7:0]  InData,
   input  logic        InValid,
   input  logic        InLast,
   output logic        InReady,
   input  logic        Abort,
   output logic [7:0]  TXdata,
   output logic        TXdataValid,
   output logic        TXdataValidMSW,
   output logic        TXfirstByte,
   output logic        TXunderrun,
   input  logic        TXack,
   output logic [15:0] FramesSent,
   output logic [15:0] FramesDropped
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_LEN - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);

   state_t            state_r;
   state_t            state_nxt;
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_addr_s;
   logic [ADDR_W:0]   len_r;
   logic [ADDR_W:0]   rd_ptr_r;
   logic [ADDR_W:0]   send_len_s;
   logic [7:0]        byte0_r;
   logic [7:0]        rd_data_s;
   logic [7:0]        tx_data_s;
   logic              tx_valid_s;
   logic              underrun_s;
   logic              in_ready_r;
   logic              aborted_r;
   logic              accept_s;
   logic              wr_en_s;
   logic              last_byte_s;
   logic [15:0]       sent_r;
   logic [15:0]       dropped_r;

   assign accept_s  = InValid && in_ready_r;
   assign wr_en_s   = accept_s && (state_r == FILL);
   // Byte 0 comes from byte0_r, so the RAM always prefetches one byte ahead.
   assign rd_addr_s = ADDR_W'(rd_ptr_r + LEN_ONE);

`ifdef ETH_TX_PAD_EN
   localparam logic [ADDR_W:0] MIN_LEN = (ADDR_W+1)'(ETH_MIN_FRAME);
   assign send_len_s = (len_r < MIN_LEN) ? MIN_LEN : len_r;
`else
   assign send_len_s = len_r;
`endif

   assign last_byte_s = (rd_ptr_r == (send_len_s - LEN_ONE));

   eth_tx_buf_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (Clock),
      .wr_en   (wr_en_s),
      .wr_addr (wr_ptr_r),
      .wr_data (InData),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   // State register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r <= FILL;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         FILL: begin
            if (accept_s && InLast) begin
               state_nxt = WAIT_ACK;
            end else if (accept_s && (wr_ptr_r == LAST_ADDR)) begin
               state_nxt = DROP;
            end else begin
               state_nxt = FILL;
            end
         end
         DROP: begin
            if (accept_s && InLast) begin
               state_nxt = FILL;
            end else begin
               state_nxt = DROP;
            end
         end
         WAIT_ACK: begin
            if (TXack) begin
               state_nxt = (send_len_s == LEN_ONE) ? GAP : SEND;
            end else begin
               state_nxt = WAIT_ACK;
            end
         end
         SEND: begin
            if (Abort || last_byte_s) begin
               state_nxt = GAP;
            end else begin
               state_nxt = SEND;
            end
         end
         GAP:     state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   // MAC-side output decode
   always_comb begin
      tx_valid_s = 1'b0;
      tx_data_s  = 8'h00;
      underrun_s = 1'b0;
      case (state_r)
         WAIT_ACK: begin
            tx_valid_s = 1'b1;
            tx_data_s  = byte0_r;
         end
         SEND: begin
            tx_valid_s = 1'b1;
            underrun_s = Abort;
`ifdef ETH_TX_PAD_EN
            if (rd_ptr_r >= len_r) begin
               tx_data_s = PAD_BYTE;
            end else begin
               tx_data_s = rd_data_s;
            end
`else
            tx_data_s = rd_data_s;
`endif
         end
         default: begin
            tx_valid_s = 1'b0;
            tx_data_s  = 8'h00;
            underrun_s = 1'b0;
         end
      endcase
   end

   // Pointers, frame length, first-byte holding register and counters
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         in_ready_r <= 1'b0;
         wr_ptr_r   <= '0;
         len_r      <= '0;
         rd_ptr_r   <= '0;
         byte0_r    <= 8'h00;
         aborted_r  <= 1'b0;
         sent_r     <= 16'd0;
         dropped_r  <= 16'd0;
      end else begin
         in_ready_r <= (state_nxt == FILL) || (state_nxt == DROP);
         case (state_r)
            FILL: begin
               if (accept_s) begin
                  if (wr_ptr_r == '0) begin
                     byte0_r <= InData;
                  end
                  if (InLast) begin
                     len_r <= {1'b0, wr_ptr_r} + LEN_ONE;
                  end else if (wr_ptr_r != LAST_ADDR) begin
                     wr_ptr_r <= wr_ptr_r + ADDR_ONE;
                  end
               end
            end
            DROP: begin
               if (accept_s && InLast) begin
                  dropped_r <= dropped_r + 16'd1;
                  wr_ptr_r  <= '0;
               end
            end
            WAIT_ACK: begin
               if (TXack) begin
                  rd_ptr_r <= LEN_ONE;
               end
            end
            SEND: begin
               if (Abort) begin
                  aborted_r <= 1'b1;
               end else begin
                  rd_ptr_r <= rd_ptr_r + LEN_ONE;
               end
            end
            GAP: begin
               if (aborted_r) begin
                  dropped_r <= dropped_r + 16'd1;
               end else begin
                  sent_r <= sent_r + 16'd1;
               end
               aborted_r <= 1'b0;
               wr_ptr_r  <= '0;
               rd_ptr_r  <= '0;
            end
            default: begin
               wr_ptr_r <= '0;
               rd_ptr_r <= '0;
            end
         endcase
      end
   end

   assign InReady        = in_ready_r;
   assign TXdata         = tx_data_s;
   assign TXdataValid    = tx_valid_s;
   assign TXunderrun     = underrun_s;
   assign TXdataValidMSW = 1'b0;
   assign TXfirstByte    = 1'b0;
   assign FramesSent     = sent_r;
   assign FramesDropped  = dropped_r;

endmodule

// File: tb/tb_eth_tx_frame_buffer.sv
// Scoreboard bench for eth_tx_frame_buffer; honours ETH_TX_PAD_EN when defined.
module tb_eth_tx_frame_buffer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [7:0]  InData = 8'h00;
   logic        InValid = 1'b0;
   logic        InLast = 1'b0;
   logic        InReady;
   logic        Abort = 1'b0;
   logic [7:0]  TXdata;
   logic        TXdataValid;
   logic        TXdataValidMSW;
   logic        TXfirstByte;
   logic        TXunderrun;
   logic        TXack = 1'b0;
   logic [15:0] FramesSent;
   logic [15:0] FramesDropped;

   eth_tx_frame_buffer dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .InData         (InData),
      .InValid        (InValid),
      .InLast         (InLast),
      .InReady        (InReady),
      .Abort          (Abort),
      .TXdata         (TXdata),
      .TXdataValid    (TXdataValid),
      .TXdataValidMSW (TXdataValidMSW),
      .TXfirstByte    (TXfirstByte),
      .TXunderrun     (TXunderrun),
      .TXack          (TXack),
      .FramesSent     (FramesSent),
      .FramesDropped  (FramesDropped)
   );

   always #5 Clock = ~Clock;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   int         exp_len_q[$];
   int         frames_done = 0;
   bit         mon_en = 1'b0;
   bit         in_frame = 1'b0;
   int         byte_idx = 0;
   int         wait_cnt = 0;
   int         ack_delay = 5;
   int         abort_at = -1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int n, input int seed, input bit pad);
      int total;
      total = n;
      for (int i = 0; i < n; i++) exp_q.push_back(8'(seed + i));
`ifdef ETH_TX_PAD_EN
      if (pad && n < 60) begin
         for (int i = n; i < 60; i++) exp_q.push_back(8'h00);
         total = 60;
      end
`endif
      exp_len_q.push_back(total);
   endtask

   task automatic drive_frame(input int len, input int seed);
      int tmo;
      for (int i = 0; i < len; i++) begin
         InValid = 1'b1;
         InData  = 8'(seed + i);
         InLast  = (i == len - 1);
         tmo = 0;
         while (!InReady && tmo < 5000) begin
            @(negedge Clock);
            tmo++;
         end
         if (!InReady) begin
            check("in_ready_tmo", {31'd0, InReady}, 32'd1);
            InValid = 1'b0;
            InLast  = 1'b0;
            return;
         end
         @(negedge Clock);
      end
      InLast = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int tmo;
      tmo = 0;
      while (frames_done < target && tmo < 8000) begin
         @(negedge Clock);
         tmo++;
      end
      if (frames_done < target) check("frames_tmo", frames_done, target);
      repeat (2) @(negedge Clock);
   endtask

   // MAC model: acknowledges byte 0, injects Abort, checks every byte against the scoreboard
   always @(negedge Clock) begin
      TXack = 1'b0;
      Abort = 1'b0;
      if (!mon_en) begin
         in_frame = 1'b0;
         byte_idx = 0;
         wait_cnt = 0;
      end else if (TXdataValid) begin
         check("ready_low_tx", {31'd0, InReady}, 32'd0);
         check("exp_avail", {31'd0, exp_q.size() != 0}, 32'd1);
         if (!in_frame) begin
            if (exp_q.size() != 0) check("hold_byte", {24'd0, TXdata}, {24'd0, exp_q[0]});
            check("underrun_idle", {31'd0, TXunderrun}, 32'd0);
            wait_cnt++;
            if (wait_cnt > ack_delay) begin
               TXack = 1'b1;
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               in_frame = 1'b1;
               byte_idx = 1;
               wait_cnt = 0;
            end
         end else begin
            if (exp_q.size() != 0) check("tx_byte", {24'd0, TXdata}, {24'd0, exp_q.pop_front()});
            if (byte_idx == abort_at) begin
               Abort = 1'b1;
               #1;
               check("underrun_abort", {31'd0, TXunderrun}, 32'd1);
               check("valid_abort", {31'd0, TXdataValid}, 32'd1);
               abort_at = -1;
            end else begin
               check("underrun_idle", {31'd0, TXunderrun}, 32'd0);
            end
            byte_idx++;
         end
      end else if (in_frame) begin
         if (exp_len_q.size() != 0) check("frame_len", byte_idx, exp_len_q.pop_front());
         else check("frame_unexpected", byte_idx, 32'd0);
         frames_done++;
         in_frame = 1'b0;
      end else begin
         wait_cnt = 0;
      end
   end

   initial begin
      int tmo;
      int base;
      repeat (3) @(negedge Clock);
      check("rst_in_ready", {31'd0, InReady}, 32'd0);
      check("rst_valid", {31'd0, TXdataValid}, 32'd0);
      check("rst_data", {24'd0, TXdata}, 32'd0);
      check("rst_underrun", {31'd0, TXunderrun}, 32'd0);
      check("rst_sent", {16'd0, FramesSent}, 32'd0);
      check("rst_dropped", {16'd0, FramesDropped}, 32'd0);
      check("msw_const", {31'd0, TXdataValidMSW}, 32'd0);
      check("first_const", {31'd0, TXfirstByte}, 32'd0);
      Reset = 1'b0;
      repeat (2) @(negedge Clock);
      check("ready_after_rst", {31'd0, InReady}, 32'd1);
      mon_en = 1'b1;

      // 64-byte frame, byte 0 held six cycles
      ack_delay = 5;
      push_exp(64, 0, 1'b1);
      drive_frame(64, 0);
      InValid = 1'b0;
      wait_frames(1);
      check("sent_1", {16'd0, FramesSent}, 32'd1);
      check("dropped_0", {16'd0, FramesDropped}, 32'd0);

      // Back-to-back 100-byte frames with InValid held high
      ack_delay = 2;
      push_exp(100, 8'h40, 1'b1);
      push_exp(100, 8'h80, 1'b1);
      drive_frame(100, 8'h40);
      drive_frame(100, 8'h80);
      InValid = 1'b0;
      wait_frames(3);
      check("sent_b2b", {16'd0, FramesSent}, 32'd3);

      // Oversize frame dropped, short frame follows
      drive_frame(1600, 8'h11);
      InValid = 1'b0;
      @(negedge Clock);
      check("dropped_big", {16'd0, FramesDropped}, 32'd1);
      check("sent_after_drop", {16'd0, FramesSent}, 32'd3);
      push_exp(20, 8'h55, 1'b1);
      drive_frame(20, 8'h55);
      InValid = 1'b0;
      wait_frames(4);
      check("sent_short", {16'd0, FramesSent}, 32'd4);

      // Exactly MAX_LEN is legal; one more byte is not
      push_exp(1514, 8'h03, 1'b1);
      drive_frame(1514, 8'h03);
      InValid = 1'b0;
      wait_frames(5);
      check("sent_max", {16'd0, FramesSent}, 32'd5);
      check("dropped_max", {16'd0, FramesDropped}, 32'd1);
      drive_frame(1515, 8'h07);
      InValid = 1'b0;
      @(negedge Clock);
      check("dropped_1515", {16'd0, FramesDropped}, 32'd2);

      // Single-byte frame
      push_exp(1, 8'hA5, 1'b1);
      drive_frame(1, 8'hA5);
      InValid = 1'b0;
      wait_frames(6);
      check("sent_single", {16'd0, FramesSent}, 32'd6);

      // Abort at byte 10, then a normal frame
      abort_at = 10;
      push_exp(11, 8'h20, 1'b0);
      drive_frame(200, 8'h20);
      InValid = 1'b0;
      wait_frames(7);
      check("dropped_abort", {16'd0, FramesDropped}, 32'd3);
      check("sent_abort", {16'd0, FramesSent}, 32'd6);
      push_exp(30, 8'h90, 1'b1);
      drive_frame(30, 8'h90);
      InValid = 1'b0;
      wait_frames(8);
      check("sent_post_abort", {16'd0, FramesSent}, 32'd7);

      // Reset while sending
      push_exp(100, 8'h33, 1'b1);
      drive_frame(100, 8'h33);
      InValid = 1'b0;
      tmo = 0;
      while (!(in_frame && byte_idx >= 5) && tmo < 5000) begin
         @(negedge Clock);
         tmo++;
      end
      check("reached_send", {31'd0, in_frame}, 32'd1);
      mon_en = 1'b0;
      @(posedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      check("async_valid", {31'd0, TXdataValid}, 32'd0);
      check("async_data", {24'd0, TXdata}, 32'd0);
      check("async_ready", {31'd0, InReady}, 32'd0);
      exp_q.delete();
      exp_len_q.delete();
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      check("rst2_sent", {16'd0, FramesSent}, 32'd0);
      check("rst2_dropped", {16'd0, FramesDropped}, 32'd0);
      @(negedge Clock);
      check("rst2_ready", {31'd0, InReady}, 32'd1);
      base = frames_done;
      mon_en = 1'b1;
      push_exp(10, 8'hC0, 1'b1);
      drive_frame(10, 8'hC0);
      InValid = 1'b0;
      wait_frames(base + 1);
      check("rst2_sent_new", {16'd0, FramesSent}, 32'd1);
      check("q_left", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
